// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// MC_ILLEGAL_TRAP_EN adds the sticky StTrap state.
package mc_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
`ifdef MC_ILLEGAL_TRAP_EN
    , StTrap
`endif
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1010;

  // Base funct3 mapping; funct7 alternates (SUB/SRA) are resolved by the caller.
  function automatic logic [3:0] f3_to_aluop(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Shared instruction/data memory port between the controller and memory.
interface mc_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);
endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode to ALU operation plus legality.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] aluop,
  output logic       legal
);

  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0) begin
          legal = 1'b1;
          aluop = f3_to_aluop(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal = 1'b1;
          aluop = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal = 1'b1;
          aluop = ALU_SRA;
        end
      end
      OP_I: begin
        case (funct3)
          3'b001: begin
            legal = (funct7 == 7'b0);
            aluop = ALU_SLL;
          end
          3'b101: begin
            legal = (funct7 == 7'b0) || (funct7 == F7_ALT);
            aluop = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          default: begin
            legal = 1'b1;
            aluop = f3_to_aluop(funct3);
          end
        endcase
      end
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_BRANCH: begin
        legal = (funct3 == 3'b000);
        aluop = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) aluop = ALU_ADD;
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for RV32I.
// Define MC_ILLEGAL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module mc_controller
  import mc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr,
  input  logic                   zero,
  mc_controller_if.master        mem,
  output logic                   ir_en,
  output logic                   pc_en,
  output logic                   pc_sel,
  output logic [3:0]             aluop,
  output logic                   alu_src_imm,
  output logic                   rf_en,
  output logic                   wb_sel,
  output logic                   illegal
);

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [3:0] dec_aluop;
  logic       dec_legal;
  logic       is_load, is_store, is_branch, is_rtype;
  logic       drive_alu;
  logic       mem_req, mem_we, mem_sel;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_rtype  = (opcode == OP_R);
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode (opcode),
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .aluop  (dec_aluop),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem.mem_ack) state_d = StDecode;
`ifdef MC_ILLEGAL_TRAP_EN
      StDecode: state_d = dec_legal ? StExec : StTrap;
      StTrap:   state_d = StTrap;
`else
      StDecode: state_d = StExec;
`endif
      StExec: begin
        if (!dec_legal || is_branch)  state_d = StFetch;
        else if (is_load || is_store) state_d = StMem;
        else                          state_d = StWb;
      end
      StMem:    if (mem.mem_ack) state_d = is_load ? StWb : StFetch;
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Outputs are forced low while rst is high; state is already StFetch then.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    rf_en     = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    drive_alu = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          ir_en   = mem.mem_ack;
        end
        StExec: begin
          drive_alu = 1'b1;
          if (!dec_legal || is_branch) pc_en = 1'b1;
          if (dec_legal && is_branch)  pc_sel = zero;
        end
        StMem: begin
          drive_alu = 1'b1;
          mem_req   = 1'b1;
          mem_sel   = 1'b1;
          mem_we    = is_store;
          pc_en     = is_store && mem.mem_ack;
        end
        StWb: begin
          drive_alu = 1'b1;
          rf_en     = 1'b1;
          wb_sel    = is_load;
          pc_en     = 1'b1;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        StTrap:  illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign aluop       = drive_alu ? dec_aluop : ALU_ADD;
  assign alu_src_imm = drive_alu && dec_legal && !is_rtype && !is_branch;

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;
  assign mem.mem_sel = mem_sel;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: expected retire records are queued by the
// driver and popped by a monitor on each pc_en pulse.
module tb_mc_controller;

  localparam int KR = 0, KI = 1, KLW = 2, KSW = 3, KBEQ = 4, KILL = 5;

  typedef struct {
    int         cycles;
    bit         pc_sel;
    bit         rf_en;
    bit         wb_sel;
    bit         chk_alu;
    logic [3:0] aluop;
    bit         src_imm;
    bit         we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        ir_en, pc_en, pc_sel, alu_src_imm, rf_en, wb_sel, illegal;
  logic [3:0]  aluop;

  mc_controller_if mem_bus ();

  mc_controller dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .zero        (zero),
    .mem         (mem_bus),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .aluop       (aluop),
    .alu_src_imm (alu_src_imm),
    .rf_en       (rf_en),
    .wb_sel      (wb_sel),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   mon_cyc, mon_irc;
  bit   mon_we, mon_rf_early;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'd0;
      3'd1: return 4'd6;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return 4'd7;
      3'd6: return 4'd9;
      default: return 4'd10;
    endcase
  endfunction

  // Reference classification straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] ins, output int kind,
                                     output logic [3:0] op);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    kind = KILL;
    op = 4'd0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin kind = KR; op = base_op(f3); end
      else if (f7 == 7'h20 && f3 == 3'd0) begin kind = KR; op = 4'd1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin kind = KR; op = 4'd8; end
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) begin kind = KI; op = 4'd6; end
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00) begin kind = KI; op = 4'd7; end
        else if (f7 == 7'h20) begin kind = KI; op = 4'd8; end
      end else begin
        kind = KI; op = base_op(f3);
      end
    end else if (opc == 7'h03 && f3 == 3'd2) kind = KLW;
    else if (opc == 7'h23 && f3 == 3'd2) kind = KSW;
    else if (opc == 7'h63 && f3 == 3'd0) begin kind = KBEQ; op = 4'd1; end
  endfunction

  function automatic exp_t build_exp(input int kind, input logic [3:0] op, input bit z,
                                     input int fw, input int mw);
    exp_t e;
    e = '{cycles: 0, pc_sel: 0, rf_en: 0, wb_sel: 0, chk_alu: 1, aluop: op, src_imm: 0, we: 0};
    case (kind)
      KR:   begin e.cycles = 4 + fw; e.rf_en = 1; end
      KI:   begin e.cycles = 4 + fw; e.rf_en = 1; e.src_imm = 1; end
      KLW:  begin e.cycles = 5 + fw + mw; e.rf_en = 1; e.wb_sel = 1; e.src_imm = 1; end
      KSW:  begin e.cycles = 4 + fw + mw; e.src_imm = 1; e.we = 1; end
      KBEQ: begin e.cycles = 3 + fw; e.pc_sel = z; end
      default: begin e.cycles = 3 + fw; e.chk_alu = 0; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int s;
    s = $urandom_range(0, 9);
    f3 = 3'($urandom);
    case (s)
      0, 1: opc = 7'h33;
      2, 3: opc = 7'h13;
      4, 8: begin opc = 7'h03; if ($urandom_range(0, 3) != 0) f3 = 3'd2; end
      5:    begin opc = 7'h23; if ($urandom_range(0, 3) != 0) f3 = 3'd2; end
      6, 9: begin opc = 7'h63; if ($urandom_range(0, 3) != 0) f3 = 3'd0; end
      default: opc = 7'($urandom);
    endcase
    s = $urandom_range(0, 5);
    if (s <= 2)      f7 = 7'h00;
    else if (s <= 4) f7 = 7'h20;
    else             f7 = 7'($urandom);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at the negedge after retire.
  task automatic run_instr(input logic [31:0] ins, input bit z, input int fw, input int mw);
    int kind, fc, mc, n;
    logic [3:0] op;
    bit done;
    ref_decode(ins, kind, op);
    exp_q.push_back(build_exp(kind, op, z, fw, mw));
    instr = ins;
    zero = z;
    fc = 0; mc = 0; n = 0; done = 0;
    while (!done) begin
      if (mem_bus.mem_req && !mem_bus.mem_sel) begin
        mem_bus.mem_ack = (fc >= fw);
        if (fc < fw) fc++;
      end else if (mem_bus.mem_req) begin
        mem_bus.mem_ack = (mc >= mw);
        if (mc < mw) mc++;
      end else begin
        mem_bus.mem_ack = 1'b0;
      end
      #1;
      if (pc_en) done = 1;
      n++;
      if (!done && n > 64) begin
        checks++;
        errors++;
        $display("FAIL retire_timeout instr=%08h actual=no_pc_en required=pc_en", ins);
        done = 1;
      end
      @(negedge clk);
    end
    mem_bus.mem_ack = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en || rst) begin
        mon_cyc = 0; mon_irc = 0; mon_we = 0; mon_rf_early = 0;
      end else begin
        mon_cyc++;
        if (mem_bus.mem_we)  mon_we = 1;
        if (rf_en && !pc_en) mon_rf_early = 1;
        if (ir_en)           mon_irc++;
        if (pc_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire actual=pc_en required=no_pc_en");
          end else begin
            e = exp_q.pop_front();
            chk("cycles", mon_cyc, e.cycles);
            chk("pc_sel", pc_sel, e.pc_sel);
            chk("rf_en", rf_en, e.rf_en);
            chk("wb_sel", wb_sel, e.wb_sel);
            chk("mem_we_seen", mon_we, e.we);
            chk("rf_en_early", mon_rf_early, 0);
            chk("ir_en_count", mon_irc, 1);
            chk("illegal_at_retire", illegal, 0);
            if (e.chk_alu) begin
              chk("aluop", aluop, e.aluop);
              chk("alu_src_imm", alu_src_imm, e.src_imm);
            end
          end
          mon_cyc = 0; mon_irc = 0; mon_we = 0; mon_rf_early = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    int kind;
    logic [3:0] op;
    bit found;
    mem_bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_sel, ir_en, pc_en, pc_sel,
                          aluop, alu_src_imm, rf_en, wb_sel, illegal}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    #1 chk("first_req", {mem_bus.mem_req, mem_bus.mem_sel}, 2'b10);
    @(negedge clk);

    run_instr(32'h002081B3, 0, 0, 0);
    run_instr(32'h0000A103, 0, 2, 1);
    run_instr(32'h0020A023, 0, 1, 2);
    run_instr(32'h00208463, 1, 0, 0);
    run_instr(32'h00208463, 0, 0, 0);
`ifndef MC_ILLEGAL_TRAP_EN
    run_instr(32'h0000007F, 0, 0, 0);
`endif
    for (int i = 0; i < 200; i++) begin
      ins = rand_instr();
`ifdef MC_ILLEGAL_TRAP_EN
      ref_decode(ins, kind, op);
      while (kind == KILL) begin
        ins = rand_instr();
        ref_decode(ins, kind, op);
      end
`endif
      run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

`ifdef MC_ILLEGAL_TRAP_EN
    instr = 32'h0000007F;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      mem_bus.mem_ack = mem_bus.mem_req;
      #1;
      if (illegal) found = 1;
      else @(negedge clk);
    end
    mem_bus.mem_ack = 1'b0;
    chk("trap_reached", found, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1 chk("trap_sticky", {illegal, pc_en, rf_en, ir_en, mem_bus.mem_req}, 5'b10000);
    end
    @(negedge clk);
`endif

    // Reset in the middle of a stalled load access.
    instr = 32'h0000A103;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_bus.mem_req && mem_bus.mem_sel) begin
        found = 1;
        mem_bus.mem_ack = 1'b0;
      end else begin
        mem_bus.mem_ack = mem_bus.mem_req;
        @(negedge clk);
      end
    end
    chk("reach_mem", found, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_mem_outputs", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_sel, ir_en, pc_en,
                                   pc_sel, aluop, alu_src_imm, rf_en, wb_sel, illegal}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_fetch", {mem_bus.mem_req, mem_bus.mem_sel, illegal}, 3'b100);
    @(negedge clk);
    mon_en = 1'b1;
    run_instr(32'h002081B3, 0, 0, 0);
    chk("queue_drained_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
